// File: rtl/perf_event_collector_pkg.sv
// Shared debug types for the perf event collector: FSM states, stream beat layout
// and the default counter width.
package perf_event_collector_pkg;

   localparam int PERF_CNT_WIDTH = 32;
   localparam int PERF_ID_WIDTH  = 8;

   typedef enum logic {
      PERF_IDLE,
      PERF_DUMP
   } perf_state_t;

   typedef struct packed {
      logic [PERF_ID_WIDTH-1:0]  id;
      logic [PERF_CNT_WIDTH-1:0] count;
      logic                      last;
   } perf_beat_t;

endpackage

// File: rtl/perf_sat_counter.sv
// One saturating event counter: clear has priority over an enabled increment, and
// the count sticks at all-ones instead of wrapping.
module perf_sat_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_i,
   input  logic                 en_i,
   input  logic                 inc_i,
   output logic [CNT_WIDTH-1:0] count_o
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && inc_i && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/perf_event_collector.sv
// Event counters plus a free-running cycle counter; on request the counters are
// snapshotted and streamed out one per beat over a valid/ready port.
module perf_event_collector
   import perf_event_collector_pkg::*;
#(
   parameter int EVENT_NUM = 16,
   parameter int CNT_WIDTH = PERF_CNT_WIDTH,
   parameter int ID_WIDTH  = $clog2(EVENT_NUM)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_i,
   input  logic [EVENT_NUM-1:0] event_i,
   input  logic                 clear_i,
   input  logic                 dump_req_i,
   output logic                 dump_busy_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [ID_WIDTH-1:0]  out_id_o,
   output logic [CNT_WIDTH-1:0] out_count_o,
   output logic                 out_last_o,
   output logic [63:0]          cycle_cnt_o
);

   localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(EVENT_NUM - 1);

   logic [CNT_WIDTH-1:0] cnt      [EVENT_NUM];
   logic [CNT_WIDTH-1:0] shadow_q [EVENT_NUM];
   logic [63:0]          cycle_q;
   perf_state_t          state_q;
   logic [ID_WIDTH-1:0]  idx_q;
   logic [ID_WIDTH-1:0]  idx_nxt;
   logic                 busy_q, valid_q, last_q;
   logic [CNT_WIDTH-1:0] count_q;

   for (genvar g = 0; g < EVENT_NUM; g++) begin : g_cnt
      perf_sat_counter #(
         .CNT_WIDTH(CNT_WIDTH)
      ) u_cnt (
         .clk    (clk),
         .rst    (rst),
         .clear_i(clear_i),
         .en_i   (en_i),
         .inc_i  (event_i[g]),
         .count_o(cnt[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_q + 64'd1;
      end
   end

   assign idx_nxt = idx_q + 1'b1;

   // Snapshot takes the counter values before this cycle's clear/increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PERF_IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         count_q <= '0;
         for (int i = 0; i < EVENT_NUM; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         case (state_q)
            PERF_IDLE: begin
               if (dump_req_i) begin
                  shadow_q <= cnt;
                  idx_q    <= '0;
                  count_q  <= cnt[0];
                  last_q   <= 1'b0;
                  valid_q  <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= PERF_DUMP;
               end
            end
            PERF_DUMP: begin
               if (out_ready_i) begin
                  if (last_q) begin
                     idx_q   <= '0;
                     last_q  <= 1'b0;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     state_q <= PERF_IDLE;
                  end else begin
                     idx_q   <= idx_nxt;
                     count_q <= shadow_q[idx_nxt];
                     last_q  <= (idx_nxt == LAST_ID);
                  end
               end
            end
            default: state_q <= PERF_IDLE;
         endcase
      end
   end

   assign dump_busy_o = busy_q;
   assign out_valid_o = valid_q;
   assign out_id_o    = idx_q;
   assign out_count_o = count_q;
   assign out_last_o  = last_q;
   assign cycle_cnt_o = cycle_q;

endmodule

// File: tb/tb_perf_event_collector.sv
// Directed bench for perf_event_collector: a 32-bit and a 4-bit counter instance
// share stimulus and are checked every cycle against a queue-based model.
module tb_perf_event_collector;

   localparam int N = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en_i = 1'b0, clear_i = 1'b0, dump_req_i = 1'b0, out_ready_i = 1'b0;
   logic [N-1:0] event_i = '0;

   logic        busy, valid, last;
   logic [3:0]  id;
   logic [31:0] cnt;
   logic [63:0] cyc;
   logic        busy4, valid4, last4;
   logic [3:0]  id4;
   logic [3:0]  cnt4;
   logic [63:0] cyc4;

   always #5 clk = ~clk;

   perf_event_collector #(.EVENT_NUM(N), .CNT_WIDTH(32)) u_dut (
      .clk(clk), .rst(rst), .en_i(en_i), .event_i(event_i), .clear_i(clear_i),
      .dump_req_i(dump_req_i), .dump_busy_o(busy), .out_valid_o(valid),
      .out_ready_i(out_ready_i), .out_id_o(id), .out_count_o(cnt),
      .out_last_o(last), .cycle_cnt_o(cyc)
   );

   perf_event_collector #(.EVENT_NUM(N), .CNT_WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .en_i(en_i), .event_i(event_i), .clear_i(clear_i),
      .dump_req_i(dump_req_i), .dump_busy_o(busy4), .out_valid_o(valid4),
      .out_ready_i(out_ready_i), .out_id_o(id4), .out_count_o(cnt4),
      .out_last_o(last4), .cycle_cnt_o(cyc4)
   );

   typedef struct {
      int     id;
      longint cnt;
      bit     last;
   } beat_t;

   beat_t       q32[$], q4[$], got[$], got4[$];
   longint      m32[N], m4[N];
   logic [63:0] m_cyc;
   int          checks = 0, errors = 0;
   bit          chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: counters as integers, a pending dump as a queue of beats.
   always @(posedge clk) begin
      if (rst) begin
         m_cyc = 64'd0;
         for (int i = 0; i < N; i++) begin
            m32[i] = 0;
            m4[i]  = 0;
         end
         q32.delete();
         q4.delete();
      end else begin
         m_cyc = m_cyc + 64'd1;
         if (q32.size() > 0) begin
            if (out_ready_i) begin
               void'(q32.pop_front());
               void'(q4.pop_front());
            end
         end else if (dump_req_i) begin
            for (int i = 0; i < N; i++) begin
               beat_t b;
               b.id = i; b.last = (i == N - 1);
               b.cnt = m32[i]; q32.push_back(b);
               b.cnt = m4[i];  q4.push_back(b);
            end
         end
         for (int i = 0; i < N; i++) begin
            if (clear_i) begin
               m32[i] = 0;
               m4[i]  = 0;
            end else if (en_i && event_i[i]) begin
               if (m32[i] < 64'hFFFF_FFFF) m32[i] = m32[i] + 1;
               if (m4[i] < 15) m4[i] = m4[i] + 1;
            end
         end
      end
   end

   logic        pv = 1'b0, pr = 1'b0, plast = 1'b0;
   logic [3:0]  pid = '0;
   logic [31:0] pcnt = '0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("cycle", cyc, m_cyc);
         check("cycle4", cyc4, m_cyc);
         check("busy", 64'(busy), 64'(q32.size() > 0));
         check("valid", 64'(valid), 64'(q32.size() > 0));
         check("busy4", 64'(busy4), 64'(q4.size() > 0));
         check("valid4", 64'(valid4), 64'(q4.size() > 0));
         if (q32.size() > 0) begin
            check("beat_id", 64'(id), 64'(q32[0].id));
            check("beat_cnt", 64'(cnt), q32[0].cnt);
            check("beat_last", 64'(last), 64'(q32[0].last));
            check("beat4_id", 64'(id4), 64'(q4[0].id));
            check("beat4_cnt", 64'(cnt4), q4[0].cnt);
            check("beat4_last", 64'(last4), 64'(q4[0].last));
         end
         if (pv && !pr && !rst) begin
            check("hold_id", 64'(id), 64'(pid));
            check("hold_cnt", 64'(cnt), 64'(pcnt));
            check("hold_last", 64'(last), 64'(plast));
         end
         if (valid && out_ready_i && !rst) begin
            beat_t b;
            b.id = int'(id); b.cnt = longint'(cnt); b.last = last;
            got.push_back(b);
            b.id = int'(id4); b.cnt = longint'(cnt4); b.last = last4;
            got4.push_back(b);
         end
      end
      pv = valid; pr = out_ready_i; pid = id; pcnt = cnt; plast = last;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic longint gc(input int i);
      return (i < got.size()) ? got[i].cnt : -1;
   endfunction

   function automatic longint gc4(input int i);
      return (i < got4.size()) ? got4[i].cnt : -1;
   endfunction

   task automatic do_dump(input bit toggle, input bit noise, input bit with_clear);
      got.delete();
      got4.delete();
      dump_req_i = 1'b1;
      if (with_clear) begin
         clear_i = 1'b1; en_i = 1'b1; event_i[2] = 1'b1;
      end
      tick(1);
      dump_req_i = 1'b0; clear_i = 1'b0; event_i = '0; en_i = 1'b0;
      for (int k = 0; k < 200 && busy; k++) begin
         out_ready_i = toggle ? (k % 3 == 0) : 1'b1;
         if (noise) begin
            en_i = 1'b1;
            event_i = N'($urandom);
            dump_req_i = (k == 4);
         end
         tick(1);
      end
      check("dump_done", 64'(busy), 64'(0));
      out_ready_i = 1'b0; dump_req_i = 1'b0; event_i = '0; en_i = 1'b0;
   endtask

   // Count beats whose id/last/count disagree with an expected per-index count.
   function automatic int bad_beats(input longint exp_cnt[N]);
      int bad = 0;
      for (int i = 0; i < N; i++) begin
         if (i >= got.size()) bad++;
         else if (got[i].id != i || got[i].cnt != exp_cnt[i] || got[i].last != (i == N - 1)) bad++;
      end
      return bad;
   endfunction

   initial begin
      longint exp_c[N];

      rst = 1'b1;
      tick(1);
      chk_en = 1'b1;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_valid", 64'(valid), 64'(0));
      check("rst_last", 64'(last), 64'(0));
      check("rst_id", 64'(id), 64'(0));
      check("rst_cycle", cyc, 64'(0));
      rst = 1'b0;

      tick(10);
      check("cycle_after_10", cyc, 64'd10);
      do_dump(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) exp_c[i] = 0;
      check("idle_dump_beats", 64'(got.size()), 64'd16);
      check("idle_dump_content", 64'(bad_beats(exp_c)), 64'(0));

      en_i = 1'b1; event_i[3] = 1'b1;
      tick(5);
      en_i = 1'b0;
      tick(3);
      event_i = '0;
      do_dump(1'b0, 1'b0, 1'b0);
      exp_c[3] = 5;
      check("ev3_content", 64'(bad_beats(exp_c)), 64'(0));
      check("ev3_cnt4", 64'(gc4(3)), 64'd5);

      clear_i = 1'b1;
      tick(1);
      clear_i = 1'b0; en_i = 1'b1; event_i[0] = 1'b1;
      tick(20);
      en_i = 1'b0; event_i = '0;
      do_dump(1'b0, 1'b0, 1'b0);
      check("ev0_cnt32", 64'(gc(0)), 64'd20);
      check("ev0_sat4", 64'(gc4(0)), 64'd15);
      check("ev3_cleared", 64'(gc(3)), 64'd0);

      clear_i = 1'b1;
      tick(1);
      clear_i = 1'b0; en_i = 1'b1; event_i[2] = 1'b1;
      tick(7);
      en_i = 1'b0; event_i = '0;
      do_dump(1'b0, 1'b0, 1'b1);
      check("clr_snapshot", 64'(gc(2)), 64'd7);
      check("clr_snapshot4", 64'(gc4(2)), 64'd7);
      do_dump(1'b0, 1'b0, 1'b0);
      check("clr_after", 64'(gc(2)), 64'd0);

      clear_i = 1'b1;
      tick(1);
      clear_i = 1'b0; en_i = 1'b1; event_i = 16'h00FF;
      tick(3);
      en_i = 1'b0; event_i = '0;
      do_dump(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < N; i++) exp_c[i] = (i < 8) ? 3 : 0;
      check("stall_beats", 64'(got.size()), 64'd16);
      check("stall_content", 64'(bad_beats(exp_c)), 64'(0));
      tick(3);
      check("midreq_ignored", 64'(busy), 64'(0));

      dump_req_i = 1'b1; out_ready_i = 1'b1;
      tick(1);
      dump_req_i = 1'b0;
      tick(5);
      check("pre_rst_id", 64'(id), 64'd5);
      rst = 1'b1;
      tick(1);
      check("abort_valid", 64'(valid), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_cycle", cyc, 64'(0));
      rst = 1'b0; out_ready_i = 1'b0;
      do_dump(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) exp_c[i] = 0;
      check("post_rst_first_id", 64'((got.size() > 0) ? got[0].id : -1), 64'(0));
      check("post_rst_content", 64'(bad_beats(exp_c)), 64'(0));

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
